fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Front-end sequencer that drives the PC register's jump, hold and JTAG-reset inputs. It arbitrates redirect requests from the execute stage, the core-local interrupt controller (CLINT) and the JTAG debug module. While the bus stalls fetch, it buffers one redirect. It also runs JTAG halt and timed reset sequences, so the PC register only sees one clean command per cycle.

## Interface
- ADDR_W, 32: instruction address width
- RESET_CYCLES, 4: cycles jtag_reset_flag_o stays high per JTAG reset request (range 1–15)
- RESET_ADDR, 32'h0: address reported on jump_addr_o while idle
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- ex_jump_req_i  in  1  execute-stage branch/jump taken
- ex_jump_addr_i  in  ADDR_W  branch/jump target
- ex_hold_req_i  in  1  execute multi-cycle op (div) busy
- int_req_i  in  1  CLINT interrupt/trap entry or mret
- int_addr_i  in  ADDR_W  trap/return target
- bus_stall_i  in  1  fetch bus not granted this cycle
- jtag_halt_req_i  in  1  level; debugger requests halt
- jtag_reset_req_i  in  1  single-cycle pulse; debugger requests core reset
- jump_flag_o  out  1  to PC register: load jump_addr_o
- jump_addr_o  out  ADDR_W  redirect target
- hold_flag_o  out  3  0 none, 1 hold PC, 2 hold PC+IF, 3 hold PC+IF+ID
- jtag_reset_flag_o  out  1  to PC register: force reset address
- halted_o  out  1  core halted, to JTAG module

## Operation
- Redirect priority: int_req_i > ex_jump_req_i. jtag_reset_req_i overrides everything.
- States: RUN, PEND, HALT, RST.
- RUN, winning redirect and bus_stall_i=0: jump_flag_o=1, jump_addr_o=winner's address, hold_flag_o=3 (flush IF/ID). Combinational, same cycle; state stays RUN.
- RUN, winning redirect and bus_stall_i=1: latch the address into pend_addr and go to PEND. Outputs: jump_flag_o=0, hold_flag_o=1.
- PEND: hold_flag_o=1 while bus_stall_i=1.
  - A new int_req_i overwrites pend_addr. A new ex_jump_req_i is ignored; execute is already flushed.
  - First cycle with bus_stall_i=0: jump_flag_o=1, jump_addr_o=pend_addr, hold_flag_o=3, then go to RUN.
- RUN, no redirect:
  - hold_flag_o=3 if ex_hold_req_i.
  - Otherwise 1 if bus_stall_i.
  - Otherwise 0.
- HALT entry: only from RUN, when jtag_halt_req_i=1 and there is no redirect this cycle and ex_hold_req_i=0. A pending redirect always completes first.
- HALT: hold_flag_o=3, halted_o=1. Redirect inputs are ignored. Leave to RUN the cycle after jtag_halt_req_i falls; the PC resumes unchanged.
- jtag_reset_req_i in any state: go to RST and load cnt=RESET_CYCLES-1. Clears pending redirect and halt.
- RST: jtag_reset_flag_o=1, hold_flag_o=3, jump_flag_o=0.
  - cnt decrements each cycle. At cnt=0, go to RUN, or to HALT if jtag_halt_req_i=1.
  - A new reset pulse while in RST reloads cnt.
- jump_addr_o=RESET_ADDR whenever jump_flag_o=0 (no stale addresses).

## Timing
- While rst=0 (async): state=RUN, pend_addr=RESET_ADDR, cnt=0. All outputs 0, except jump_addr_o=RESET_ADDR.
- Outputs are decoded combinationally from the registered state and current inputs. Only state, pend_addr and cnt are registered.
- RUN redirect latency: 0 cycles; the PC loads the target at the next clk edge.
- PEND redirect latency: issued in the first unstalled cycle; the PC loads at the following edge.
- jtag_reset_flag_o: high for exactly RESET_CYCLES consecutive cycles, starting the cycle after the pulse.
- halted_o: rises 1 cycle after jtag_halt_req_i is sampled in an eligible RUN cycle. Falls 1 cycle after the request falls.
- Simultaneous int_req_i and ex_jump_req_i: int address wins; the ex jump is dropped, because the trap flushes it.
- Simultaneous jtag_reset_req_i and any redirect: reset wins; no jump_flag_o is issued.
- Simultaneous jtag_halt_req_i and a redirect: the redirect is issued first and the halt takes effect on the next eligible cycle.
- rst asserted mid-PEND or mid-RST: the buffered address and count are discarded immediately.

## Test plan
- Reset release, no requests, bus idle → hold_flag_o=0, jump_flag_o=0, jump_addr_o=0 every cycle.
- ex_jump_req_i=1, addr 0x100, bus_stall_i=0 → same cycle: jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3; next cycle: jump_flag_o=0.
- ex_jump to 0x200 with bus_stall_i=1 for 3 cycles, and int_req_i to 0x80 in stall cycle 2 → hold_flag_o=1 for 3 cycles, then jump_flag_o=1, jump_addr_o=0x80, single cycle.
- jtag_halt_req_i high for 5 cycles while in RUN → halted_o=1 from cycle 2 to cycle 6 and hold_flag_o=3. A ex_jump_req_i during the halt produces no jump_flag_o.
- jtag_reset_req_i pulse while in PEND with RESET_CYCLES=4 → jtag_reset_flag_o=1 for 4 cycles, the pending redirect is never issued, then the block returns to RUN with hold_flag_o=0.
- ex_hold_req_i=1 with bus_stall_i=1 → hold_flag_o=3; drop ex_hold_req_i → hold_flag_o=1; drop the stall → hold_flag_o=0.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// Redirect/hold command bundle between the front-end sequencer and its neighbours.
// Latency: none; plain wires.
// Backpressure: bus_stall_i is the only stall input; the command outputs carry no handshake.
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ex_jump_req_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              ex_hold_req_i;
  logic              int_req_i;
  logic [ADDR_W-1:0] int_addr_i;
  logic              bus_stall_i;
  logic              jtag_halt_req_i;
  logic              jtag_reset_req_i;
  logic              jump_flag_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic [2:0]        hold_flag_o;
  logic              jtag_reset_flag_o;
  logic              halted_o;

  // Sequencer side: consumes requests, drives PC-register commands.
  modport master (
    input  ex_jump_req_i, ex_jump_addr_i, ex_hold_req_i, int_req_i, int_addr_i,
           bus_stall_i, jtag_halt_req_i, jtag_reset_req_i,
    output jump_flag_o, jump_addr_o, hold_flag_o, jtag_reset_flag_o, halted_o
  );

  // Environment side: raises requests, observes commands.
  modport slave (
    output ex_jump_req_i, ex_jump_addr_i, ex_hold_req_i, int_req_i, int_addr_i,
           bus_stall_i, jtag_halt_req_i, jtag_reset_req_i,
    input  jump_flag_o, jump_addr_o, hold_flag_o, jtag_reset_flag_o, halted_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Front-end sequencer: arbitrates redirects, buffers one redirect under bus stall, runs JTAG halt/reset.
// Latency: unstalled redirect issued combinationally in the request cycle; buffered one in the first unstalled cycle.
// Backpressure: bus_stall_i parks a redirect in PEND and holds the PC until the bus is granted.
module fetch_ctrl #(
  parameter int                 ADDR_W       = 32,
  parameter int                 RESET_CYCLES = 4,
  parameter logic [ADDR_W-1:0]  RESET_ADDR   = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {RUN, PEND, HALT, RST} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(RESET_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_nxt;
  logic [3:0]        cnt, cnt_nxt;

  logic              redir;
  logic [ADDR_W-1:0] redir_addr;
  logic              jump_flag;
  logic [ADDR_W-1:0] jump_tgt;
  logic [2:0]        hold_flag;
  logic              reset_flag;
  logic              halted;

  // Interrupt/trap beats an execute jump: the trap flushes that jump anyway.
  assign redir      = bus.int_req_i | bus.ex_jump_req_i;
  assign redir_addr = bus.int_req_i ? bus.int_addr_i : bus.ex_jump_addr_i;

  // State register plus the buffered redirect target and reset-sequence counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      pend_addr <= RESET_ADDR;
      cnt       <= 4'd0;
    end else begin
      state     <= state_nxt;
      pend_addr <= pend_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Next-state decode; a JTAG reset pulse preempts everything and drops any buffered redirect.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_addr;
    cnt_nxt   = cnt;
    if (bus.jtag_reset_req_i) begin
      state_nxt = RST;
      cnt_nxt   = CNT_LOAD;
      pend_nxt  = RESET_ADDR;
    end else begin
      case (state)
        RUN: begin
          if (redir) begin
            if (bus.bus_stall_i) begin
              state_nxt = PEND;
              pend_nxt  = redir_addr;
            end
          end else if (bus.jtag_halt_req_i && !bus.ex_hold_req_i) begin
            state_nxt = HALT;
          end
        end
        PEND: begin
          if (!bus.bus_stall_i) begin
            state_nxt = RUN;
            pend_nxt  = RESET_ADDR;
          end else if (bus.int_req_i) begin
            // A later trap replaces the parked target; a later ex jump is already flushed.
            pend_nxt = bus.int_addr_i;
          end
        end
        HALT: begin
          if (!bus.jtag_halt_req_i) state_nxt = RUN;
        end
        RST: begin
          if (cnt == 4'd0) state_nxt = bus.jtag_halt_req_i ? HALT : RUN;
          else             cnt_nxt   = cnt - 4'd1;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Output decode from registered state and live inputs; forced quiet while reset is held.
  always_comb begin
    jump_flag  = 1'b0;
    jump_tgt   = pend_addr;
    hold_flag  = 3'd0;
    reset_flag = 1'b0;
    halted     = 1'b0;
    case (state)
      RUN: begin
        if (redir && !bus.jtag_reset_req_i) begin
          if (!bus.bus_stall_i) begin
            jump_flag = 1'b1;
            jump_tgt  = redir_addr;
            hold_flag = 3'd3;
          end else begin
            hold_flag = 3'd1;
          end
        end else if (bus.ex_hold_req_i) begin
          hold_flag = 3'd3;
        end else if (bus.bus_stall_i) begin
          hold_flag = 3'd1;
        end
      end
      PEND: begin
        if (bus.bus_stall_i) begin
          hold_flag = 3'd1;
        end else begin
          hold_flag = 3'd3;
          jump_flag = !bus.jtag_reset_req_i;
          jump_tgt  = bus.int_req_i ? bus.int_addr_i : pend_addr;
        end
      end
      HALT: begin
        hold_flag = 3'd3;
        halted    = 1'b1;
      end
      RST: begin
        hold_flag  = 3'd3;
        reset_flag = 1'b1;
      end
      default: hold_flag = 3'd0;
    endcase
    if (!rst) begin
      jump_flag  = 1'b0;
      hold_flag  = 3'd0;
      reset_flag = 1'b0;
      halted     = 1'b0;
    end
  end

  // Target only appears alongside jump_flag so the PC never sees a stale address.
  assign bus.jump_flag_o       = jump_flag;
  assign bus.jump_addr_o       = jump_flag ? jump_tgt : RESET_ADDR;
  assign bus.hold_flag_o       = hold_flag;
  assign bus.jtag_reset_flag_o = reset_flag;
  assign bus.halted_o          = halted;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle stimulus pushes expected outputs, a monitor pops and compares.
// Latency: expectations refer to the same cycle the stimulus is applied.
// Backpressure: bus_stall_i patterns are driven directly from the vectors.
module tb_fetch_ctrl;

  typedef struct packed {
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hf;
    logic        rf;
    logic        hd;
  } exp_t;

  logic clk;
  logic rst;

  logic        ex_j, ex_h, int_r, stall, halt, rreq;
  logic [31:0] ex_a, int_a;

  exp_t  expq[$];
  string nameq[$];
  int    total;
  int    bad;

  fetch_ctrl_if #(.ADDR_W(32)) ifc ();

  assign ifc.ex_jump_req_i    = ex_j;
  assign ifc.ex_jump_addr_i   = ex_a;
  assign ifc.ex_hold_req_i    = ex_h;
  assign ifc.int_req_i        = int_r;
  assign ifc.int_addr_i       = int_a;
  assign ifc.bus_stall_i      = stall;
  assign ifc.jtag_halt_req_i  = halt;
  assign ifc.jtag_reset_req_i = rreq;

  fetch_ctrl #(.ADDR_W(32), .RESET_CYCLES(4), .RESET_ADDR(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are observed every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t  e;
      exp_t  a;
      string n;
      e = expq.pop_front();
      n = nameq.pop_front();
      a = '{ifc.jump_flag_o, ifc.jump_addr_o, ifc.hold_flag_o, ifc.jtag_reset_flag_o, ifc.halted_o};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got jf=%0d ja=%h hf=%0d rf=%0d hd=%0d, want jf=%0d ja=%h hf=%0d rf=%0d hd=%0d",
                 n, a.jf, a.ja, a.hf, a.rf, a.hd, e.jf, e.ja, e.hf, e.rf, e.hd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_j = 0; ex_a = 0; ex_h = 0; int_r = 0; int_a = 0; stall = 0; halt = 0; rreq = 0;
  endtask

  task automatic expect_out(input string n, input logic jf, input logic [31:0] ja,
                            input logic [2:0] hf, input logic rf, input logic hd);
    exp_t e;
    e = '{jf, ja, hf, rf, hd};
    expq.push_back(e);
    nameq.push_back(n);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();

    // Held in reset: outputs quiet even with a live request.
    tick(); expect_out("reset_idle", 0, 0, 0, 0, 0);
    tick(); ex_j = 1; ex_a = 32'h100; expect_out("reset_gated", 0, 0, 0, 0, 0);
    tick(); idle(); rst = 1'b1; expect_out("idle0", 0, 0, 0, 0, 0);
    tick(); expect_out("idle1", 0, 0, 0, 0, 0);
    tick(); expect_out("idle2", 0, 0, 0, 0, 0);

    // Unstalled execute jump.
    tick(); ex_j = 1; ex_a = 32'h100; expect_out("ex_jump", 1, 32'h100, 3, 0, 0);
    tick(); idle(); expect_out("ex_jump_after", 0, 0, 0, 0, 0);

    // Interrupt beats execute jump in the same cycle.
    tick(); ex_j = 1; ex_a = 32'h150; int_r = 1; int_a = 32'h90; expect_out("int_wins", 1, 32'h90, 3, 0, 0);

    // Stalled redirect, overwritten by a trap while parked.
    tick(); idle(); ex_j = 1; ex_a = 32'h200; stall = 1; expect_out("pend_s1", 0, 0, 1, 0, 0);
    tick(); ex_j = 0; int_r = 1; int_a = 32'h80; expect_out("pend_s2", 0, 0, 1, 0, 0);
    tick(); int_r = 0; int_a = 0; expect_out("pend_s3", 0, 0, 1, 0, 0);
    tick(); stall = 0; expect_out("pend_issue", 1, 32'h80, 3, 0, 0);
    tick(); expect_out("pend_done", 0, 0, 0, 0, 0);

    // Halt for 5 cycles; jump during halt ignored.
    tick(); halt = 1; expect_out("halt_c1", 0, 0, 0, 0, 0);
    tick(); expect_out("halt_c2", 0, 0, 3, 0, 1);
    tick(); ex_j = 1; ex_a = 32'h300; expect_out("halt_c3_jump", 0, 0, 3, 0, 1);
    tick(); ex_j = 0; ex_a = 0; expect_out("halt_c4", 0, 0, 3, 0, 1);
    tick(); expect_out("halt_c5", 0, 0, 3, 0, 1);
    tick(); halt = 0; expect_out("halt_c6", 0, 0, 3, 0, 1);
    tick(); expect_out("halt_c7", 0, 0, 0, 0, 0);

    // Halt together with a redirect: redirect first, halt next cycle.
    tick(); halt = 1; ex_j = 1; ex_a = 32'h400; expect_out("halt_redir", 1, 32'h400, 3, 0, 0);
    tick(); ex_j = 0; ex_a = 0; expect_out("halt_after_redir", 0, 0, 0, 0, 0);
    tick(); halt = 0; expect_out("halt_after_redir_hd", 0, 0, 3, 0, 1);
    tick(); expect_out("halt_after_redir_run", 0, 0, 0, 0, 0);

    // JTAG reset while a redirect is parked.
    tick(); ex_j = 1; ex_a = 32'h500; stall = 1; expect_out("rp_pend", 0, 0, 1, 0, 0);
    tick(); ex_j = 0; ex_a = 0; rreq = 1; expect_out("rp_pulse", 0, 0, 1, 0, 0);
    tick(); rreq = 0; stall = 0; expect_out("rp_rst1", 0, 0, 3, 1, 0);
    tick(); expect_out("rp_rst2", 0, 0, 3, 1, 0);
    tick(); expect_out("rp_rst3", 0, 0, 3, 1, 0);
    tick(); expect_out("rp_rst4", 0, 0, 3, 1, 0);
    tick(); expect_out("rp_run", 0, 0, 0, 0, 0);

    // Reset pulse with a redirect, reload mid-sequence, exit into halt.
    tick(); ex_j = 1; ex_a = 32'h600; rreq = 1; expect_out("rr_pulse_redir", 0, 0, 0, 0, 0);
    tick(); ex_j = 0; ex_a = 0; rreq = 0; expect_out("rr_c1", 0, 0, 3, 1, 0);
    tick(); rreq = 1; expect_out("rr_c2_reload", 0, 0, 3, 1, 0);
    tick(); rreq = 0; expect_out("rr_c3", 0, 0, 3, 1, 0);
    tick(); expect_out("rr_c4", 0, 0, 3, 1, 0);
    tick(); expect_out("rr_c5", 0, 0, 3, 1, 0);
    tick(); halt = 1; expect_out("rr_c6", 0, 0, 3, 1, 0);
    tick(); expect_out("rr_halt", 0, 0, 3, 0, 1);
    tick(); halt = 0; expect_out("rr_halt_fall", 0, 0, 3, 0, 1);
    tick(); expect_out("rr_run", 0, 0, 0, 0, 0);

    // Hold priority: execute hold over bus stall.
    tick(); ex_h = 1; stall = 1; expect_out("hold_both", 0, 0, 3, 0, 0);
    tick(); ex_h = 0; expect_out("hold_stall", 0, 0, 1, 0, 0);
    tick(); stall = 0; expect_out("hold_none", 0, 0, 0, 0, 0);

    // Execute hold blocks halt entry.
    tick(); ex_h = 1; halt = 1; expect_out("halt_blocked", 0, 0, 3, 0, 0);
    tick(); ex_h = 0; expect_out("halt_unblocked", 0, 0, 0, 0, 0);
    tick(); halt = 0; expect_out("halt_unblocked_hd", 0, 0, 3, 0, 1);
    tick(); expect_out("halt_unblocked_run", 0, 0, 0, 0, 0);

    // Async reset mid-PEND discards the parked target.
    tick(); ex_j = 1; ex_a = 32'h700; stall = 1; expect_out("ar_pend", 0, 0, 1, 0, 0);
    tick(); ex_j = 0; ex_a = 0; expect_out("ar_pend2", 0, 0, 1, 0, 0);
    #6; rst = 1'b0; stall = 0;
    tick(); expect_out("ar_in_reset", 0, 0, 0, 0, 0);
    tick(); rst = 1'b1; expect_out("ar_released", 0, 0, 0, 0, 0);
    tick(); expect_out("ar_run", 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    begin
      int guard;
      guard = 0;
      while (expq.size() > 0 && guard < 20) begin
        @(posedge clk);
        guard++;
      end
      if (expq.size() > 0) begin
        bad++;
        $display("FAIL drain: got %0d pending, want 0", expq.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
